// File: rtl/counter_table_sched.sv
`default_nettype none
// counter_table_sched: read-port arbiter (lookup over attenuation sweep) plus in-order update FIFO
// drain for the 128-entry 2-bit branch counter table.  Rev 1.0
module counter_table_sched #(
  parameter int UPQ_DEPTH    = 4,
  parameter int DECAY_PERIOD = 4096,
  parameter int RD_LAT       = 1
) (
  input  logic       Clk,
  input  logic       Rest,
  input  logic       LkValid,
  input  logic [6:0] LkAddr,
  output logic       LkReady,
  output logic       RspValid,
  output logic [1:0] RspData,
  input  logic       UpValid,
  input  logic [6:0] UpAddr,
  input  logic       UpTaken,
  output logic       UpReady,
  input  logic       DecayReq,
  output logic       DecayBusy,
  output logic [6:0] TbRaddr,
  output logic       TbRable,
  output logic       TbAtten,
  output logic [6:0] TbWaddr,
  output logic       TbWable,
  output logic       TbWdate,
  input  logic [1:0] TbRdate
);

  localparam int TMR_W = $clog2(DECAY_PERIOD);
  localparam int QA_W  = $clog2(UPQ_DEPTH);
  localparam int CNT_W = QA_W + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DECAY_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(UPQ_DEPTH);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SWEEP = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [6:0]       ptr, ptr_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             lk_acc, sweep_rd;

  logic [6:0]       q_addr [UPQ_DEPTH];
  logic             q_dir  [UPQ_DEPTH];
  logic [QA_W-1:0]  wr_idx, rd_idx;
  logic [CNT_W-1:0] count;
  logic [6:0]       head_addr;
  logic             push, pop, stall;
  logic [RD_LAT-1:0] rsp_pipe;

  assign lk_acc  = LkValid;
  assign LkReady = 1'b1;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    timer_nxt = timer;
    sweep_rd  = 1'b0;
    case (state)
      S_IDLE: begin
        if (DecayReq || (timer == TMR_LAST)) begin
          state_nxt = S_SWEEP;
          ptr_nxt   = 7'd0;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      S_SWEEP: begin
        timer_nxt = '0;
        // A lookup owns the read port; the sweep simply waits a cycle.
        if (!lk_acc) begin
          sweep_rd = 1'b1;
          ptr_nxt  = ptr + 7'd1;
          if (ptr == 7'd127) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      state <= S_IDLE;
      ptr   <= 7'd0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      timer <= timer_nxt;
    end
  end

  assign TbRable   = lk_acc | sweep_rd;
  assign TbRaddr   = lk_acc ? LkAddr : (sweep_rd ? ptr : 7'd0);
  assign TbAtten   = sweep_rd;
  assign DecayBusy = (state == S_SWEEP);

  assign head_addr = q_addr[rd_idx];
  assign UpReady   = (count != CNT_FULL);
  assign push      = UpValid && UpReady;
  // Never write the entry the sweep is attenuating in the same cycle.
  assign stall     = sweep_rd && (ptr == head_addr);
  assign pop       = (count != '0) && !stall;

  assign TbWable = pop;
  assign TbWaddr = pop ? head_addr : 7'd0;
  assign TbWdate = pop && q_dir[rd_idx];

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + QA_W'(1);
      if (pop)  rd_idx <= rd_idx + QA_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      q_addr[wr_idx] <= UpAddr;
      q_dir[wr_idx]  <= UpTaken;
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) rsp_pipe <= '0;
        else      rsp_pipe <= lk_acc;
      end
    end else begin : g_latn
      always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) rsp_pipe <= '0;
        else      rsp_pipe <= {rsp_pipe[RD_LAT-2:0], lk_acc};
      end
    end
  endgenerate

  assign RspValid = rsp_pipe[RD_LAT-1];
  assign RspData  = RspValid ? TbRdate : 2'b00;

  a_no_push_when_full: assert property (@(posedge Clk) disable iff (Rest) !(UpValid && !UpReady));

endmodule
`default_nettype wire

// File: tb/tb_counter_table_sched.sv
`default_nettype none
// tb_counter_table_sched: directed stimulus, queue-based reference model checked every cycle,
// plus hand-computed literal expectations.
module tb_counter_table_sched;

  localparam int DP = 256;

  logic       clk, Rest;
  logic       LkValid, UpValid, UpTaken, DecayReq;
  logic [6:0] LkAddr, UpAddr;
  logic       LkReady, RspValid, UpReady, DecayBusy, TbRable, TbAtten, TbWable, TbWdate;
  logic [1:0] RspData, TbRdate;
  logic [6:0] TbRaddr, TbWaddr;

  counter_table_sched #(.UPQ_DEPTH(4), .DECAY_PERIOD(DP), .RD_LAT(1)) dut (
    .Clk(clk), .Rest(Rest), .LkValid(LkValid), .LkAddr(LkAddr), .LkReady(LkReady),
    .RspValid(RspValid), .RspData(RspData), .UpValid(UpValid), .UpAddr(UpAddr),
    .UpTaken(UpTaken), .UpReady(UpReady), .DecayReq(DecayReq), .DecayBusy(DecayBusy),
    .TbRaddr(TbRaddr), .TbRable(TbRable), .TbAtten(TbAtten), .TbWaddr(TbWaddr),
    .TbWable(TbWable), .TbWdate(TbWdate), .TbRdate(TbRdate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] sat_upd(input logic [1:0] v, input logic up);
    if (up) return (v == 2'd3) ? 2'd3 : v + 2'd1;
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

  function automatic logic [1:0] attn(input logic [1:0] v);
    return v[1] ? 2'b10 : 2'b01;
  endfunction

  // Table environment: the cycle's read, attenuation and write take effect at its end.
  logic [1:0] tbl [128];
  logic [1:0] rd_pend;
  initial begin
    for (int i = 0; i < 128; i++) tbl[i] = 2'b01;
    tbl[7'h45] = 2'b10;
    rd_pend = 2'b00;
    TbRdate = 2'b00;
  end
  always @(negedge clk) begin
    if (TbRable) rd_pend = tbl[TbRaddr];
    if (TbRable && TbAtten) tbl[TbRaddr] = attn(tbl[TbRaddr]);
    if (TbWable) tbl[TbWaddr] = sat_upd(tbl[TbWaddr], TbWdate);
  end
  always @(posedge clk) TbRdate <= rd_pend;

  // Reference model
  typedef struct { logic [6:0] a; logic d; } upd_t;
  upd_t       m_q[$];
  bit         m_sweep, m_rv;
  int         m_ptr, m_timer;
  logic [1:0] m_rd;
  logic [1:0] m_table [128];
  initial begin
    for (int i = 0; i < 128; i++) m_table[i] = 2'b01;
    m_table[7'h45] = 2'b10;
  end

  always @(negedge clk) begin
    bit e_srd, e_rable, e_wable, m_push;
    if (Rest) begin
      m_sweep = 0; m_ptr = 0; m_timer = 0; m_rv = 0;
      m_q.delete();
    end else begin
      e_srd   = m_sweep && !LkValid;
      e_rable = LkValid || e_srd;
      e_wable = (m_q.size() > 0) && !(e_srd && (m_q[0].a == 7'(m_ptr)));
      chk("LkReady", LkReady, 1);
      chk("TbRable", TbRable, e_rable);
      if (e_rable) chk("TbRaddr", TbRaddr, LkValid ? LkAddr : 7'(m_ptr));
      chk("TbAtten", TbAtten, e_srd);
      chk("DecayBusy", DecayBusy, m_sweep);
      chk("UpReady", UpReady, m_q.size() < 4);
      chk("RspValid", RspValid, m_rv);
      if (m_rv) chk("RspData", RspData, m_rd);
      chk("TbWable", TbWable, e_wable);
      if (e_wable) begin
        chk("TbWaddr", TbWaddr, m_q[0].a);
        chk("TbWdate", TbWdate, m_q[0].d);
      end
      m_rv = LkValid;
      if (LkValid) m_rd = m_table[LkAddr];
      if (m_sweep) begin
        m_timer = 0;
        if (e_srd) begin
          m_table[m_ptr] = attn(m_table[m_ptr]);
          if (m_ptr == 127) m_sweep = 0;
          m_ptr = (m_ptr + 1) % 128;
        end
      end else if (DecayReq || m_timer == DP - 1) begin
        m_sweep = 1; m_ptr = 0; m_timer = 0;
      end else begin
        m_timer++;
      end
      m_push = UpValid && (m_q.size() < 4);
      if (e_wable) begin
        m_table[m_q[0].a] = sat_upd(m_table[m_q[0].a], m_q[0].d);
        void'(m_q.pop_front());
      end
      if (m_push) m_q.push_back('{UpAddr, UpTaken});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ok, bad, busy_n, rsp_n;
    logic [6:0] got[$];
    Rest = 1'b1; LkValid = 0; LkAddr = 0; UpValid = 0; UpAddr = 0; UpTaken = 0; DecayReq = 0;
    step(); step();
    #1;
    chk("rst_TbRable", TbRable, 0);   chk("rst_TbAtten", TbAtten, 0);
    chk("rst_TbWable", TbWable, 0);   chk("rst_UpReady", UpReady, 1);
    chk("rst_DecayBusy", DecayBusy, 0); chk("rst_RspValid", RspValid, 0);

    // Start a sweep, a lookup and updates, then reset mid-cycle with all of them in flight.
    step(); Rest = 1'b0;
    DecayReq = 1; UpValid = 1; UpAddr = 7'd3; UpTaken = 1; LkValid = 1; LkAddr = 7'd9;
    step(); DecayReq = 0; LkValid = 0; UpAddr = 7'd4;
    #1;
    chk("pre_rst_RspValid", RspValid, 1); chk("pre_rst_DecayBusy", DecayBusy, 1);
    chk("pre_rst_TbWable", TbWable, 1);
    #1; Rest = 1'b1; UpValid = 0;
    #1;
    chk("midrst_TbRable", TbRable, 0);   chk("midrst_TbAtten", TbAtten, 0);
    chk("midrst_TbWable", TbWable, 0);   chk("midrst_UpReady", UpReady, 1);
    chk("midrst_DecayBusy", DecayBusy, 0); chk("midrst_RspValid", RspValid, 0);
    step(); Rest = 1'b0; cyc = 0;

    // Single lookup, RD_LAT=1
    step(); LkValid = 1; LkAddr = 7'h45;
    #1;
    chk("lk45_TbRable", TbRable, 1); chk("lk45_TbRaddr", TbRaddr, 'h45); chk("lk45_TbAtten", TbAtten, 0);
    step(); LkValid = 0;
    #1;
    chk("lk45_RspValid", RspValid, 1); chk("lk45_RspData", RspData, 2);

    // Idle updates interleaved with lookups: no bypass, saturation, ordering
    step(); UpValid = 1; UpAddr = 7'h45; UpTaken = 1;
    step(); LkValid = 1; LkAddr = 7'h45;
    step(); UpAddr = 7'd10; UpTaken = 0;
    #1; chk("nobypass_RspData", RspData, 2);
    step(); UpValid = 0;
    #1; chk("after_inc_RspData", RspData, 3);
    step(); LkAddr = 7'd10;
    #1; chk("saturate_RspData", RspData, 3);
    step(); LkValid = 0;
    #1; chk("dec_RspData", RspData, 0);

    // Automatic sweep start
    n = 0;
    while (!DecayBusy && n < 400) begin step(); #1; n++; end
    chk("auto_start_cycles", cyc, 256);

    // Update to the address the sweep attenuates next cycle stalls that write only
    n = 0;
    while (m_ptr != 4 && n < 200) begin step(); n++; end
    UpValid = 1; UpAddr = 7'd5; UpTaken = 1;
    step(); UpValid = 0;
    #1;
    chk("collide_TbWable", TbWable, 0); chk("collide_TbRaddr", TbRaddr, 5);
    step(); #1;
    chk("release_TbWable", TbWable, 1); chk("release_TbWaddr", TbWaddr, 5);

    // Fill the FIFO by chasing the sweep pointer, then drain in order
    n = 0;
    while (m_ptr != 20 && n < 200) begin step(); n++; end
    for (int i = 0; i < 30; i++) begin
      if (i > 0) step();
      UpValid = (i <= 7) && (i != 6);
      UpAddr  = 7'(21 + 2 * ((i == 7) ? 6 : i));
      UpTaken = i[0];
      #1;
      if (i == 5) chk("fill_UpReady_5", UpReady, 1);
      if (i == 6) chk("fill_UpReady_6", UpReady, 0);
      if (i == 7) chk("fill_UpReady_7", UpReady, 1);
      if (TbWable) got.push_back(TbWaddr);
    end
    UpValid = 0;
    chk("drain_count", got.size(), 7);
    for (int k = 0; k < 7 && k < got.size(); k++) chk("drain_order", got[k], 21 + 2 * k);

    n = 0;
    while (DecayBusy && n < 300) begin step(); #1; n++; end
    chk("sweep1_end", DecayBusy, 0);

    // Forced sweep, no lookups
    step(); DecayReq = 1;
    step(); DecayReq = 0;
    ok = 0;
    for (int j = 0; j <= 128; j++) begin
      #1;
      if (j < 128 && TbAtten && TbRaddr == 7'(j)) ok++;
      if (j == 127) chk("sweep_busy_last", DecayBusy, 1);
      if (j == 128) chk("sweep_busy_129", DecayBusy, 0);
      step();
    end
    chk("sweep_atten_cycles", ok, 128);

    // Forced sweep with a lookup every other cycle
    step(); DecayReq = 1;
    step(); DecayReq = 0;
    busy_n = 0; rsp_n = 0; bad = 0;
    for (int j = 0; j <= 257; j++) begin
      LkValid = (j < 256) && (j % 2 == 0);
      LkAddr  = 7'(j);
      #1;
      if (DecayBusy) busy_n++;
      if (RspValid) begin
        rsp_n++;
        if (j % 2 == 0) bad++;
      end
      step();
    end
    LkValid = 0;
    chk("stall_busy_cycles", busy_n, 256);
    chk("stall_rsp_count", rsp_n, 128);
    chk("stall_sweep_rsp", bad, 0);

    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
